// File: rtl/textio_token_parser.sv
// Splits an ASCII character stream into typed whitespace-separated tokens (INT/HEX/BOOL/WORD/ERR)
// and counts lines. Optional macro TEXTIO_NEG_INT_EN enables leading '-' on decimal integers.
module textio_token_parser #(
  parameter int unsigned VAL_W  = 64,
  parameter int unsigned LINE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [2:0]        tok_type,
  output logic [VAL_W-1:0]  tok_value,
  output logic              tok_eol,
  output logic [LINE_W-1:0] line_count
);

  localparam int unsigned CNT_W = 3;
  localparam logic [2:0] T_INT  = 3'd0;
  localparam logic [2:0] T_HEX  = 3'd1;
  localparam logic [2:0] T_BOOL = 3'd2;
  localparam logic [2:0] T_WORD = 3'd3;
  localparam logic [2:0] T_ERR  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_WORD, S_HEX, S_HEX_END, S_BAD
  } state_t;

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         first_q, first_d;
  logic               neg_q, neg_d;
  logic               tok_valid_q, tok_valid_d;
  logic [2:0]         tok_type_q, tok_type_d;
  logic [VAL_W-1:0]   tok_value_q, tok_value_d;
  logic               tok_eol_q, tok_eol_d;
  logic [LINE_W-1:0]  line_q, line_d;

  // Character classification
  logic is_cr, is_lf, is_ws, is_term, is_dig, is_hex, is_prt, is_quote;
  always_comb begin
    is_cr    = (in_char == 8'h0D);
    is_lf    = (in_char == 8'h0A);
    is_ws    = (in_char == 8'h20) || (in_char == 8'h09);
    is_term  = is_ws || is_lf;
    is_dig   = (in_char >= 8'h30) && (in_char <= 8'h39);
    is_hex   = is_dig || ((in_char >= 8'h41) && (in_char <= 8'h46)) ||
               ((in_char >= 8'h61) && (in_char <= 8'h66));
    is_prt   = (in_char >= 8'h21) && (in_char <= 8'h7E);
    is_quote = (in_char == 8'h22);
  end

  function automatic logic [3:0] hex_nib(input logic [7:0] ch);
    if (ch <= 8'h39) return ch[3:0];
    return ch[3:0] + 4'd9;
  endfunction

  state_t           src_state;
  logic [VAL_W-1:0] src_acc;
  logic [CNT_W-1:0] src_cnt;
  logic [7:0]       src_first;
  logic             src_neg;
  logic             close;
  logic [31:0]      lc4;

  // Next-state, accumulator and output-register logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    neg_d       = neg_q;
    tok_valid_d = tok_valid_q;
    tok_type_d  = tok_type_q;
    tok_value_d = tok_value_q;
    tok_eol_d   = tok_eol_q;
    line_d      = line_q;
    close       = 1'b0;
    src_state   = state_q;
    src_acc     = acc_q;
    src_cnt     = cnt_q;
    src_first   = first_q;
    src_neg     = neg_q;

    if (tok_valid_q && tok_ready) tok_valid_d = 1'b0;

    if (in_valid && !tok_valid_q) begin
      if (is_lf || in_last) line_d = line_q + LINE_W'(1);
      if (is_term && state_q != S_IDLE) begin
        close   = 1'b1;
        state_d = S_IDLE;
      end else if (!is_cr && !is_term) begin
        unique case (state_q)
          S_IDLE: begin
            if (is_dig) begin
              state_d = S_DEC;
              acc_d   = VAL_W'(in_char - 8'h30);
              cnt_d   = CNT_W'(1);
              neg_d   = 1'b0;
`ifdef TEXTIO_NEG_INT_EN
            end else if (in_char == 8'h2D) begin
              state_d = S_DEC;
              acc_d   = '0;
              cnt_d   = '0;
              neg_d   = 1'b1;
`endif
            end else if (is_prt) begin
              state_d = S_WORD;
              acc_d   = VAL_W'(in_char);
              cnt_d   = CNT_W'(1);
              first_d = in_char;
              neg_d   = 1'b0;
            end
          end
          S_DEC: begin
            if (is_dig) begin
              acc_d = (acc_q << 3) + (acc_q << 1) + VAL_W'(in_char - 8'h30);
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = S_BAD;
            end
          end
          S_WORD: begin
            if (cnt_q == CNT_W'(1) && (first_q | 8'h20) == 8'h78 && is_quote) begin
              state_d = S_HEX;
              acc_d   = '0;
            end else begin
              acc_d = {acc_q[VAL_W-9:0], in_char};
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_HEX: begin
            if (is_hex)        acc_d   = {acc_q[VAL_W-5:0], hex_nib(in_char)};
            else if (is_quote) state_d = S_HEX_END;
            else               state_d = S_BAD;
          end
          S_HEX_END: state_d = S_BAD;
          default:   state_d = S_BAD;
        endcase
      end

      // Final character of the file flushes whatever token is still open
      if (!close && in_last && state_d != S_IDLE) begin
        close     = 1'b1;
        src_state = state_d;
        src_acc   = acc_d;
        src_cnt   = cnt_d;
        src_first = first_d;
        src_neg   = neg_d;
        state_d   = S_IDLE;
      end
    end

    lc4 = src_acc[31:0] | 32'h2020_2020;
    if (close) begin
      tok_valid_d = 1'b1;
      tok_eol_d   = is_lf || in_last;
      tok_type_d  = T_ERR;
      tok_value_d = '0;
      unique case (src_state)
        S_DEC: begin
          if (src_neg && src_cnt == '0) begin
            tok_type_d  = T_WORD;
            tok_value_d = VAL_W'(8'h2D);
          end else begin
            tok_type_d  = T_INT;
            tok_value_d = src_neg ? (~src_acc + VAL_W'(1)) : src_acc;
          end
        end
        S_HEX_END: begin
          tok_type_d  = T_HEX;
          tok_value_d = src_acc;
        end
        S_WORD: begin
          if (src_cnt == CNT_W'(4) && lc4 == 32'h7472_7565) begin
            tok_type_d  = T_BOOL;
            tok_value_d = VAL_W'(1);
          end else if (src_cnt == CNT_W'(5) && (src_first | 8'h20) == 8'h66 &&
                       lc4 == 32'h616C_7365) begin
            tok_type_d  = T_BOOL;
            tok_value_d = '0;
          end else begin
            tok_type_d  = T_WORD;
            tok_value_d = src_acc;
          end
        end
        default: begin
          tok_type_d  = T_ERR;
          tok_value_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      neg_q       <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_type_q  <= '0;
      tok_value_q <= '0;
      tok_eol_q   <= 1'b0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      neg_q       <= neg_d;
      tok_valid_q <= tok_valid_d;
      tok_type_q  <= tok_type_d;
      tok_value_q <= tok_value_d;
      tok_eol_q   <= tok_eol_d;
      line_q      <= line_d;
    end
  end

  assign in_ready   = !tok_valid_q;
  assign tok_valid  = tok_valid_q;
  assign tok_type   = tok_type_q;
  assign tok_value  = tok_value_q;
  assign tok_eol    = tok_eol_q;
  assign line_count = line_q;

endmodule

// File: doc/textio_token_parser.md
Name: textio_token_parser

Overview:
- Upstream feeder for the textio line-reading stage. Takes a stream of ASCII characters from a text file, one character per handshake.
- Splits the stream into whitespace-separated tokens and classifies each token as decimal integer, VHDL hex literal, boolean or plain word.
- Emits one typed token per handshake and keeps a running count of completed lines.
- The downstream record assembler uses these tokens to fill integer, hex, boolean and string fields.

Parameters:
- VAL_W, 64: token value width in bits. Must be a multiple of 8 and at least 32.
- LINE_W, 32: width of the line counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a character is offered.
- in_ready  out  1  the block accepts the character this cycle.
- in_char  in  8  ASCII character.
- in_last  in  1  marks the final character of the file.
- tok_valid  out  1  a token is held on the output.
- tok_ready  in  1  downstream accepts the token.
- tok_type  out  3  token type: 0 INT, 1 HEX, 2 BOOL, 3 WORD, 7 ERR.
- tok_value  out  VAL_W  token payload.
- tok_eol  out  1  the token was closed by LF or by in_last.
- line_count  out  LINE_W  number of LF characters accepted, plus 1 if in_last is accepted on a non-LF character.

Behaviour:
- Reset values: tok_valid=0, tok_type=0, tok_value=0, tok_eol=0, line_count=0. FSM returns to IDLE and all accumulators clear. Reset can be asserted mid-token or while a token is held; the partial token or held token is discarded.
- Handshakes:
  - in_ready = !tok_valid (the output is one stage deep).
  - A character is accepted when in_valid && in_ready.
  - A token transfers when tok_valid && tok_ready. tok_type, tok_value and tok_eol stay stable while tok_valid=1.
- Character classes:
  - Whitespace: 0x20, 0x09.
  - Line feed: 0x0A.
  - 0x0D is ignored in every state.
- FSM states: IDLE, DEC, WORD, HEX, HEX_END, BAD.
- IDLE:
  - Whitespace and LF are skipped.
  - '0'-'9' goes to DEC with acc = digit.
  - Any other printable character goes to WORD with acc = char and firstx = (char is 'x' or 'X').
- DEC:
  - On a digit, acc = acc*10 + digit, truncated to VAL_W bits (wraps silently).
  - Any other non-terminator goes to BAD.
- WORD:
  - If firstx=1, exactly one character has been seen, and the char is '"', go to HEX with acc = 0.
  - Otherwise acc = {acc[VAL_W-9:0], char} and the character count increments. The last VAL_W/8 characters are kept, left-zero-padded like a Verilog string.
- HEX:
  - On 0-9/a-f/A-F, acc = {acc[VAL_W-5:0], nibble}.
  - On '"', go to HEX_END.
  - On any other char, go to BAD.
- HEX_END: any non-terminator goes to BAD.
- BAD: absorbs characters until a terminator.
- Token close: a terminator (whitespace or LF) in DEC, WORD, HEX_END or BAD closes the token.
  - In the same cycle the token is loaded into the output and the FSM returns to IDLE.
  - tok_valid rises the cycle after the terminator is accepted (latency 1).
  - tok_type/tok_value by state:
    - DEC gives INT/acc.
    - HEX_END gives HEX/acc.
    - BAD gives ERR/0.
    - WORD whose text matches "true" or "false" case-insensitively gives BOOL/1 or 0.
    - Any other WORD gives WORD/acc.
  - A terminator in HEX (unterminated literal) gives ERR/0.
- Empty hex: x"" is HEX with value 0.
- tok_eol = 1 when the closing terminator was LF.
- line_count increments on every accepted LF, including LFs in IDLE and on empty lines. Wraps at 2^LINE_W.
- in_last:
  - The character is first processed normally.
  - If a token is still open after that, it is flushed as if by LF (tok_eol=1).
  - If the last character is not LF, line_count increments once more.
  - The FSM then returns to IDLE.
- Simultaneous output transfer and input arrival: in_ready reflects the registered tok_valid, so a new character is accepted one cycle after a token transfer. No combinational path from tok_ready to in_ready.

Optional Feature:
- Macro: TEXTIO_NEG_INT_EN.
- Defined:
  - '-' in IDLE goes to DEC with neg=1 and acc=0.
  - On close, INT value = -acc (two's complement).
  - A lone "-" gives WORD with value 0x2D.
- Undefined: '-' starts a WORD token like any other printable character.

Test Plan:
- Stream "string 123 true x\"F3\"\n" with tok_ready=1 -> tokens (WORD,"string"), (INT,123), (BOOL,1), (HEX,0xF3,eol=1); line_count=1.
- Stream "a\n\n\nb\n\nc" with in_last set on 'c' -> WORD tokens 'a' (eol), 'b' (eol), 'c' (eol); final line_count=6.
- Hold tok_ready=0 for 5 cycles after first token of "12 34\n" -> in_ready=0 throughout, tok_value stays 12; on release, 34 follows with no characters lost.
- Stream "12a x\"G1\" x\"1\n" -> (ERR,0), (ERR,0), (ERR,0,eol=1).
- Assert rst_n=0 after "98" of "9876 " and resume with "5 " -> single token INT 5, line_count=0.
- With TEXTIO_NEG_INT_EN defined, stream "-42 - FALSE\n" -> (INT,-42), (WORD,0x2D), (BOOL,0,eol=1).
